// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - M-stage load/store controller: valid/ready data-bus request, response wait, W-stage stall
// Load data is aligned/extended on the response edge; access_err pulses in DONE for faulted accesses.
module mem_access_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        M_in_op,
  input  logic [2:0]        M_in_f3,
  input  logic [ADDR_W-1:0] M_in_addr,
  input  logic [31:0]       M_in_wdata,
  output logic              waiting,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [31:0]       bus_req_wdata,
  output logic [3:0]        bus_req_wstrb,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rsp_rdata,
  input  logic              bus_rsp_err,
  output logic [31:0]       ld_data,
  output logic              access_err
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int         CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t           state;
  logic             is_load;
  logic             is_store;
  logic             mem_op;
  logic             f3_ok;
  logic             misalign;
  logic             bad;
  logic [3:0]       strb_n;
  logic [31:0]      wdata_n;
  logic [2:0]       ld_f3;
  logic [1:0]       ld_off;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      shifted;
  logic [31:0]      ld_next;

  assign is_load  = (M_in_op == OP_LOAD);
  assign is_store = (M_in_op == OP_STORE);
  assign mem_op   = is_load | is_store;
  assign waiting  = mem_op & (state != DONE);

  always_comb begin
    f3_ok    = 1'b0;
    misalign = 1'b0;
    if (is_load)
      f3_ok = (M_in_f3 == 3'b000) || (M_in_f3 == 3'b001) || (M_in_f3 == 3'b010) ||
              (M_in_f3 == 3'b100) || (M_in_f3 == 3'b101);
    else if (is_store)
      f3_ok = (M_in_f3 == 3'b000) || (M_in_f3 == 3'b001) || (M_in_f3 == 3'b010);
    if (M_in_f3[1:0] == 2'b01)
      misalign = M_in_addr[0];
    else if (M_in_f3[1:0] == 2'b10)
      misalign = (M_in_addr[1:0] != 2'b00);
    bad = !f3_ok || misalign;
  end

  // Store lanes: data is replicated so the byte enables alone select the target bytes.
  always_comb begin
    strb_n  = 4'b0000;
    wdata_n = M_in_wdata;
    case (M_in_f3[1:0])
      2'b00: begin
        wdata_n = {4{M_in_wdata[7:0]}};
        strb_n  = 4'b0001 << M_in_addr[1:0];
      end
      2'b01: begin
        wdata_n = {2{M_in_wdata[15:0]}};
        strb_n  = M_in_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: strb_n = 4'b1111;
    endcase
    if (!is_store)
      strb_n = 4'b0000;
  end

  always_comb begin
    shifted = bus_rsp_rdata >> {ld_off, 3'b000};
    case (ld_f3)
      3'b000:  ld_next = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_next = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_next = {24'd0, shifted[7:0]};
      3'b101:  ld_next = {16'd0, shifted[15:0]};
      default: ld_next = shifted;
    endcase
  end

  // access_err doubles as the error flag: it is only ever set on the edge into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus_req_valid <= 1'b0;
      bus_req_we    <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_wstrb <= '0;
      ld_data       <= '0;
      access_err    <= 1'b0;
      ld_f3         <= '0;
      ld_off        <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            if (bad) begin
              access_err <= 1'b1;
              state      <= DONE;
            end else begin
              bus_req_valid <= 1'b1;
              bus_req_we    <= is_store;
              bus_req_addr  <= {M_in_addr[ADDR_W-1:2], 2'b00};
              bus_req_wdata <= wdata_n;
              bus_req_wstrb <= strb_n;
              ld_f3         <= M_in_f3;
              ld_off        <= M_in_addr[1:0];
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= RSP;
          end
        end
        RSP: begin
          if (bus_rsp_valid) begin
            access_err <= bus_rsp_err;
            if (!bus_req_we)
              ld_data <= ld_next;
            state <= DONE;
          end else if (cnt == CNT_MAX) begin
            access_err <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          access_err <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

  localparam int         ADDR_W = 32;
  localparam int         TO     = 8;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] NOP    = 7'b0010011;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [6:0]        M_in_op = NOP;
  logic [2:0]        M_in_f3 = 3'b000;
  logic [ADDR_W-1:0] M_in_addr = '0;
  logic [31:0]       M_in_wdata = '0;
  logic              waiting;
  logic              bus_req_valid;
  logic              bus_req_ready = 1'b0;
  logic              bus_req_we;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [31:0]       bus_req_wdata;
  logic [3:0]        bus_req_wstrb;
  logic              bus_rsp_valid = 1'b0;
  logic [31:0]       bus_rsp_rdata = '0;
  logic              bus_rsp_err = 1'b0;
  logic [31:0]       ld_data;
  logic              access_err;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .M_in_op(M_in_op), .M_in_f3(M_in_f3), .M_in_addr(M_in_addr), .M_in_wdata(M_in_wdata),
    .waiting(waiting),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err),
    .ld_data(ld_data), .access_err(access_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        req;
    logic [31:0] ld;
    logic        err;
    int          waitc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] addr, input logic we, input logic [3:0] wstrb,
                              input logic [31:0] wdata, input logic req, input logic [31:0] ld,
                              input logic err, input int waitc);
    exp_t e;
    e.addr = addr; e.we = we; e.wstrb = wstrb; e.wdata = wdata;
    e.req = req; e.ld = ld; e.err = err; e.waitc = waitc;
    return e;
  endfunction

  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int rdy_dly, input int rsp_dly,
                       input logic [31:0] rdata, input logic rerr, input logic no_rsp, input exp_t e);
    exp_t x;
    int   wcnt, rq, rc, cyc;
    logic pend, in_rsp, seen, done;
    sb_q.push_back(e);
    @(posedge clk); #1;
    M_in_op = op; M_in_f3 = f3; M_in_addr = addr; M_in_wdata = wd;
    bus_rsp_rdata = rdata; bus_rsp_err = rerr;
    wcnt = 0; rq = 0; rc = 0; cyc = 0; pend = 0; in_rsp = 0; seen = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (!waiting) begin
        x = sb_q.pop_front();
        check("wait_cycles", wcnt, x.waitc);
        check("req_issued", {31'd0, seen}, {31'd0, x.req});
        check("ld_data", ld_data, x.ld);
        check("access_err", {31'd0, access_err}, {31'd0, x.err});
        check("valid_in_done", {31'd0, bus_req_valid}, 32'd0);
        M_in_op = NOP; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        done = 1;
      end else if (cyc >= 1000) begin
        check("op_completes_in_bound", {31'd0, waiting}, 32'd0);
        x = sb_q.pop_front();
        M_in_op = NOP; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        done = 1;
      end else begin
        wcnt++; cyc++;
        if (pend) begin
          in_rsp = 1; pend = 0;
        end
        bus_rsp_valid = in_rsp && !no_rsp && (rc == rsp_dly);
        if (in_rsp) rc++;
        if (bus_req_valid) begin
          seen = 1;
          check("req_addr", bus_req_addr, sb_q[0].addr);
          check("req_we", {31'd0, bus_req_we}, {31'd0, sb_q[0].we});
          check("req_wstrb", {28'd0, bus_req_wstrb}, {28'd0, sb_q[0].wstrb});
          if (sb_q[0].we) check("req_wdata", bus_req_wdata, sb_q[0].wdata);
          bus_req_ready = (rq >= rdy_dly);
          if (bus_req_ready) pend = 1;
          rq++;
        end else begin
          bus_req_ready = 1'b0;
        end
      end
    end
    @(negedge clk);
    check("err_pulse_over", {31'd0, access_err}, 32'd0);
    check("idle_not_waiting", {31'd0, waiting}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, bus_req_valid}, 32'd0);
    check("rst_we", {31'd0, bus_req_we}, 32'd0);
    check("rst_addr", bus_req_addr, 32'd0);
    check("rst_wdata", bus_req_wdata, 32'd0);
    check("rst_wstrb", {28'd0, bus_req_wstrb}, 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_access_err", {31'd0, access_err}, 32'd0);
    check("rst_nop_waiting", {31'd0, waiting}, 32'd0);
    M_in_op = LOAD; #1;
    check("rst_load_waiting", {31'd0, waiting}, 32'd1);
    M_in_op = NOP;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nop_waiting", {31'd0, waiting}, 32'd0);
      check("nop_no_req", {31'd0, bus_req_valid}, 32'd0);
    end

    do_op(LOAD, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0,
          mk(32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3));
    do_op(LOAD, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80112233, 1'b0, 1'b0,
          mk(32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, 3));
    do_op(LOAD, 3'b100, 32'h103, 32'h0, 1, 0, 32'h80112233, 1'b0, 1'b0,
          mk(32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h00000080, 1'b0, 4));
    do_op(LOAD, 3'b101, 32'h102, 32'h0, 0, 2, 32'h80112233, 1'b0, 1'b0,
          mk(32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h00008011, 1'b0, 5));
    do_op(LOAD, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80112233, 1'b0, 1'b0,
          mk(32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hFFFF8011, 1'b0, 3));
    do_op(LOAD, 3'b000, 32'h101, 32'h0, 0, 0, 32'h80112233, 1'b0, 1'b0,
          mk(32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h00000022, 1'b0, 3));
    do_op(STORE, 3'b000, 32'h201, 32'h000000A5, 3, 0, 32'h12345678, 1'b0, 1'b0,
          mk(32'h200, 1'b1, 4'b0010, 32'hA5A5A5A5, 1'b1, 32'h00000022, 1'b0, 6));
    do_op(STORE, 3'b001, 32'h202, 32'h0000BEEF, 0, 0, 32'h12345678, 1'b0, 1'b0,
          mk(32'h200, 1'b1, 4'b1100, 32'hBEEFBEEF, 1'b1, 32'h00000022, 1'b0, 3));
    do_op(STORE, 3'b010, 32'h204, 32'hCAFEF00D, 0, 1, 32'h12345678, 1'b1, 1'b0,
          mk(32'h204, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h00000022, 1'b1, 4));
    do_op(LOAD, 3'b010, 32'h102, 32'h0, 0, 0, 32'h55555555, 1'b0, 1'b0,
          mk(32'h0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h00000022, 1'b1, 1));
    do_op(STORE, 3'b001, 32'h201, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0,
          mk(32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h00000022, 1'b1, 1));
    do_op(STORE, 3'b100, 32'h200, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0,
          mk(32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h00000022, 1'b1, 1));
    do_op(LOAD, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0,
          mk(32'h0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h00000022, 1'b1, 1));
    do_op(LOAD, 3'b010, 32'h108, 32'h0, 0, 0, 32'h0BADF00D, 1'b1, 1'b0,
          mk(32'h108, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0BADF00D, 1'b1, 3));
    do_op(LOAD, 3'b010, 32'h10C, 32'h0, 0, 0, 32'h77777777, 1'b0, 1'b1,
          mk(32'h10C, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0BADF00D, 1'b1, TO + 2));

    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hFFFFFFFF; bus_rsp_err = 1'b1;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    check("late_rsp_ld_data", ld_data, 32'h0BADF00D);
    check("late_rsp_no_err", {31'd0, access_err}, 32'd0);

    @(posedge clk); #1;
    M_in_op = LOAD; M_in_f3 = 3'b010; M_in_addr = 32'h100; bus_rsp_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_valid", {31'd0, bus_req_valid}, 32'd1);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, bus_req_valid}, 32'd0);
    check("midrst_waiting", {31'd0, waiting}, 32'd1);
    check("midrst_ld_data", ld_data, 32'd0);
    M_in_op = NOP; #1;
    check("midrst_nop_waiting", {31'd0, waiting}, 32'd0);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hAAAAAAAA;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    check("post_rst_stray_rsp", ld_data, 32'd0);
    do_op(LOAD, 3'b010, 32'h100, 32'h0, 0, 0, 32'h11223344, 1'b0, 1'b0,
          mk(32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h11223344, 1'b0, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
